// File: rtl/pe_row_drain.sv
// Output collector for the 16-PE systolic row: skewed capture, requantize, serialize over valid/ready.
// Optional DRAIN_SAT_EN: clamp requantized results instead of wrapping them.
module pe_row_drain #(
   parameter int unsigned NUM_PE    = 16,
   parameter int unsigned IN_WIDTH  = 12,
   parameter int unsigned OUT_WIDTH = 8,
   parameter int unsigned SHIFT     = 4,
   parameter int unsigned PE_LAT    = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_PE*IN_WIDTH-1:0]   pe_in,
   input  logic                         row_start,
   input  logic [7:0]                   vec_len,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_WIDTH-1:0]         out_data,
   output logic [3:0]                   out_idx,
   output logic                         out_last,
   output logic                         acc_clr,
   output logic                         busy,
   output logic                         overrun
);

   localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int unsigned CNT_W = $clog2(PE_LAT + 256) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CAPTURE,
      S_DRAIN
   } state_t;

`ifdef DRAIN_SAT_EN
   localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [IN_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [IN_WIDTH-1:0] x);
      logic signed [IN_WIDTH-1:0] r;
      r = x >>> SHIFT;
      if (r > SAT_MAX) begin
         return OUT_WIDTH'(SAT_MAX);
      end else if (r < SAT_MIN) begin
         return OUT_WIDTH'(SAT_MIN);
      end else begin
         return OUT_WIDTH'(r);
      end
   endfunction
`else
   function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [IN_WIDTH-1:0] x);
      return OUT_WIDTH'(x >>> SHIFT);
   endfunction
`endif

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       cap_idx_q, cap_idx_d;
   logic [IDX_W-1:0]       drain_idx_q, drain_idx_d;
   logic [OUT_WIDTH-1:0]   res_q [NUM_PE];
   logic [OUT_WIDTH-1:0]   res_d [NUM_PE];
   logic                   out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
   logic [IDX_W-1:0]       out_idx_q, out_idx_d;
   logic                   out_last_q, out_last_d;
   logic                   acc_clr_q, acc_clr_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;

   logic                   start_ok;
   logic [CNT_W-1:0]       wait_load;
   logic signed [IN_WIDTH-1:0] cap_slice;

   assign start_ok  = row_start && (state_q == S_IDLE) && (vec_len != 8'd0);
   assign wait_load = CNT_W'(PE_LAT) + CNT_W'(vec_len) - CNT_W'(1);
   assign cap_slice = pe_in[32'(cap_idx_q) * IN_WIDTH +: IN_WIDTH];

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_idx_d   = cap_idx_q;
      drain_idx_d = drain_idx_q;
      res_d       = res_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      acc_clr_d   = 1'b0;
      overrun_d   = overrun_q;

      if (row_start && !start_ok) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               cnt_d     = wait_load;
               cap_idx_d = '0;
               // Zero total latency means PE0 is captured in the very next cycle.
               state_d   = (wait_load == '0) ? S_CAPTURE : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            res_d[cap_idx_q] = requant(cap_slice);
            cap_idx_d        = cap_idx_q + IDX_W'(1);
            if (cap_idx_q == LAST_IDX) begin
               state_d     = S_DRAIN;
               acc_clr_d   = 1'b1;
               drain_idx_d = '0;
               out_valid_d = 1'b1;
               out_data_d  = res_d[0];
               out_idx_d   = '0;
               out_last_d  = (NUM_PE == 1);
            end
         end
         S_DRAIN: begin
            if (out_valid_q && out_ready) begin
               if (drain_idx_q == LAST_IDX) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else begin
                  drain_idx_d = drain_idx_q + IDX_W'(1);
                  out_data_d  = res_q[drain_idx_d];
                  out_idx_d   = drain_idx_d;
                  out_last_d  = (drain_idx_d == LAST_IDX);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cap_idx_q   <= '0;
         drain_idx_q <= '0;
         for (int i = 0; i < int'(NUM_PE); i++) begin
            res_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         acc_clr_q   <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_idx_q   <= cap_idx_d;
         drain_idx_q <= drain_idx_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         acc_clr_q   <= acc_clr_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = 4'(out_idx_q);
   assign out_last  = out_last_q;
   assign acc_clr   = acc_clr_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule
